// File: rtl/rcv_d_pkg.sv
// Shared types and default sizing for the serial frame receiver.
package rcv_d_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rcv_state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/rcv_d_tmr.sv
// Inter-strobe idle counter; expired flags TIMEOUT idle clocks since the last clear.
module rcv_d_tmr
    import rcv_d_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == TW'(TIMEOUT));

endmodule

// File: rtl/rcv_d_ctrl.sv
// Serial frame receiver: LSB-first payload, optional even parity, one-deep
// holding register with overflow detection and inter-strobe timeout.
module rcv_d_ctrl
    import rcv_d_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PARITY_EN = 1,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              bit_stb,
    input  logic              bit_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              ovf_err,
    output logic              to_err,
    output logic              busy
);

    // state  | meaning
    // IDLE   | waiting for sof
    // SHIFT  | collecting payload bits
    // PARITY | waiting for the parity bit

    localparam int CW = $clog2(DATA_W + 1);

    rcv_state_t        state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [DATA_W-1:0] frame_data;
    logic              last_bit;
    logic              par_ok;
    logic              frame_done;
    logic              can_load;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expired;

    assign shreg_nxt  = {bit_in, shreg[DATA_W-1:1]};
    assign last_bit   = (bit_cnt == CW'(DATA_W - 1));
    assign par_ok     = ~^{shreg, bit_in};
    assign can_load   = !out_valid || out_ready;
    assign frame_data = (state == PARITY) ? shreg : shreg_nxt;
    assign busy       = (state != IDLE);

    // sof outranks a strobe in the same cycle in every state
    assign frame_done = bit_stb && !sof &&
                        (((state == SHIFT) && last_bit && (PARITY_EN == 0)) ||
                         ((state == PARITY) && par_ok));

    assign tmr_clr = (state == IDLE) || sof || bit_stb;
    assign tmr_en  = (state != IDLE);

    rcv_d_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            to_err  <= 1'b0;
        end else begin
            par_err <= 1'b0;
            to_err  <= 1'b0;
            if (sof) begin
                bit_cnt <= '0;
                shreg   <= '0;
                state   <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        if (bit_stb) begin
                            shreg   <= shreg_nxt;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (last_bit) begin
                                state <= (PARITY_EN != 0) ? PARITY : IDLE;
                            end
                        end else if (tmr_expired) begin
                            to_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    PARITY: begin
                        if (bit_stb) begin
                            par_err <= !par_ok;
                            state   <= IDLE;
                        end else if (tmr_expired) begin
                            to_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            ovf_err <= 1'b0;
            if (frame_done && can_load) begin
                out_data  <= frame_data;
                out_valid <= 1'b1;
            end else begin
                if (frame_done) begin
                    ovf_err <= 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
